// File: rtl/usadd_ctrl_pkg.sv
// usadd_ctrl_pkg: shared FSM encoding, default sizes and lane width helper (USADD_CTRL_BIPOLAR_EN adds a sign bit per lane)
package usadd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int LANES_DEF = 4;
    localparam int LENW_DEF  = 8;

    function automatic int lane_w(input int cw);
`ifdef USADD_CTRL_BIPOLAR_EN
        return cw + 1;
`else
        return cw;
`endif
    endfunction

endpackage

// File: rtl/usadd_window_ctrl_lane_cnt.sv
// usadd_lane_cnt: per-lane saturating 1s counter with sync clear; USADD_CTRL_BIPOLAR_EN converts to 2*count-len on cvt
module usadd_lane_cnt
    import usadd_ctrl_pkg::*;
#(
    parameter int CW   = 8,
    parameter int LENW = 8
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   clr,
    input  logic                   inc,
`ifdef USADD_CTRL_BIPOLAR_EN
    input  logic                   cvt,
    input  logic [LENW-1:0]        len,
`endif
    output logic [lane_w(CW)-1:0]  value
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // next count: clear wins, otherwise count up and stick at all-ones
    always_comb cnt_nx = clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;

    // raw count register
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) cnt <= '0;
        else cnt <= cnt_nx;

`ifdef USADD_CTRL_BIPOLAR_EN
    logic [CW:0] bip;

    // signed result uses the count including the final drain sample
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) bip <= '0;
        else if (clr) bip <= '0;
        else if (cvt) bip <= {cnt_nx, 1'b0} - (CW+1)'(len);

    assign value = bip;
`else
    assign value = cnt;
`endif

endmodule

// File: rtl/usadd_window_ctrl.sv
// usadd_window_ctrl: clears a uSADD bank, opens a len-cycle stream window and publishes per-lane 1s counts (option: USADD_CTRL_BIPOLAR_EN)
module usadd_window_ctrl
    import usadd_ctrl_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int LENW  = LENW_DEF,
    parameter int CW    = LENW
) (
    input  logic                          iClk,
    input  logic                          iRstN,
    input  logic                          iStart,
    input  logic [LENW-1:0]               iLen,
    input  logic [LANES-1:0]              iC,
    output logic                          oLaneRstN,
    output logic                          oStreamEn,
    output logic                          oBusy,
    output logic                          oDone,
    output logic [LANES*lane_w(CW)-1:0]   oCount
);

    localparam int OW = lane_w(CW);

    state_t          state;
    state_t          state_nx;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] rem;
    logic            en_d1;

    // next state; start is only honoured while idle or done
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = iStart ? CLEAR : IDLE;
            CLEAR:   state_nx = (len_q == '0) ? DONE : RUN;
            RUN:     state_nx = (rem == LENW'(1)) ? DRAIN : RUN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = iStart ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, window bookkeeping and registered lane controls
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) begin
            state     <= IDLE;
            len_q     <= '0;
            rem       <= '0;
            en_d1     <= 1'b0;
            oLaneRstN <= 1'b1;
            oStreamEn <= 1'b0;
        end else begin
            state     <= state_nx;
            if ((state == IDLE || state == DONE) && iStart) len_q <= iLen;
            rem       <= (state == CLEAR) ? len_q : (state == RUN) ? rem - 1'b1 : rem;
            en_d1     <= oStreamEn;
            oLaneRstN <= state_nx != CLEAR;
            oStreamEn <= state_nx == RUN;
        end

    assign oBusy = state != IDLE;
    assign oDone = state == DONE;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        usadd_lane_cnt #(.CW(CW), .LENW(LENW)) u_lane (
            .iClk  (iClk),
            .iRstN (iRstN),
            .clr   (state == CLEAR),
            .inc   (en_d1 & iC[i]),
`ifdef USADD_CTRL_BIPOLAR_EN
            .cvt   (state_nx == DONE),
            .len   (len_q),
`endif
            .value (oCount[i*OW +: OW])
        );
    end

endmodule

// File: tb/tb_usadd_window_ctrl.sv
// tb_usadd_window_ctrl: directed scoreboard bench for usadd_window_ctrl (honours USADD_CTRL_BIPOLAR_EN)
module tb_usadd_window_ctrl;

    localparam int LANES = 4;
    localparam int LENW  = 8;
    localparam int CW    = 8;
`ifdef USADD_CTRL_BIPOLAR_EN
    localparam int OW = CW + 1;
`else
    localparam int OW = CW;
`endif

    logic                  iClk   = 1'b0;
    logic                  iRstN  = 1'b1;
    logic                  iStart = 1'b0;
    logic [LENW-1:0]       iLen   = '0;
    logic [LANES-1:0]      iC     = '0;
    logic                  oLaneRstN;
    logic                  oStreamEn;
    logic                  oBusy;
    logic                  oDone;
    logic [LANES*OW-1:0]   oCount;

    logic [LANES*OW-1:0]   sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    usadd_window_ctrl #(.LANES(LANES), .LENW(LENW), .CW(CW)) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iStart    (iStart),
        .iLen      (iLen),
        .iC        (iC),
        .oLaneRstN (oLaneRstN),
        .oStreamEn (oStreamEn),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oCount    (oCount)
    );

    task automatic chk(input string tag, input logic [LANES*OW-1:0] obs, input logic [LANES*OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*OW-1:0] exp_vec(input int c[LANES], input int len);
        logic [LANES*OW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef USADD_CTRL_BIPOLAR_EN
            v[i*OW +: OW] = OW'(2*c[i] - len);
`else
            v[i*OW +: OW] = OW'(c[i]);
`endif
        end
        return v;
    endfunction

    function automatic logic [LANES-1:0] bits(input int h[LANES], input int j);
        logic [LANES-1:0] b;
        for (int i = 0; i < LANES; i++) b[i] = j < h[i];
        return b;
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // scoreboard: every done pulse must match the oldest pending window
    always @(negedge iClk)
        if (oDone) begin
            chkb("done_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) chk("done_count", oCount, sb.pop_front());
        end

    // lane i sees iC=1 in the first h[i] counted cycles; noise is driven where nothing may count
    task automatic run_window(input int len, input int h[LANES]);
        int c[LANES];
        for (int i = 0; i < LANES; i++) c[i] = (h[i] < len) ? h[i] : len;
        sb.push_back(exp_vec(c, len));
        iStart = 1'b1;
        iLen   = LENW'(len);
        step();
        iStart = 1'b0;
        iLen   = LENW'($urandom);
        iC     = '1;
        chkb("clear_lane_rst", oLaneRstN, 1'b0);
        chkb("clear_busy", oBusy, 1'b1);
        chkb("clear_stream", oStreamEn, 1'b0);
        for (int r = 1; r <= len; r++) begin
            step();
            chkb("run_stream", oStreamEn, 1'b1);
            chkb("run_lane_rst", oLaneRstN, 1'b1);
            if (r == 1) chk("run1_cleared", oCount, '0);
            iC = (r == 1) ? '1 : bits(h, r - 2);
        end
        if (len > 0) begin
            step();
            chkb("drain_stream", oStreamEn, 1'b0);
            chkb("drain_done", oDone, 1'b0);
            iC = bits(h, len - 1);
        end
        step();
        chkb("done_pulse", oDone, 1'b1);
        chkb("done_stream", oStreamEn, 1'b0);
        iC = '1;
        step();
        chkb("idle_busy", oBusy, 1'b0);
        chkb("idle_done", oDone, 1'b0);
        chk("idle_hold", oCount, exp_vec(c, len));
        iC = '0;
    endtask

    initial begin
        #2 iRstN = 1'b0;
        #10;
        chkb("rst_lane_rst", oLaneRstN, 1'b1);
        chkb("rst_stream", oStreamEn, 1'b0);
        chkb("rst_busy", oBusy, 1'b0);
        chkb("rst_done", oDone, 1'b0);
        chk("rst_count", oCount, '0);
        step();
        iRstN = 1'b1;
        step();

        iStart = 1'b1;
        iLen   = 8'd10;
        iC     = '1;
        step();
        iStart = 1'b0;
        repeat (4) step();
        chkb("mid_run_stream", oStreamEn, 1'b1);
        iRstN = 1'b0;
        #1;
        chkb("abort_lane_rst", oLaneRstN, 1'b1);
        chkb("abort_stream", oStreamEn, 1'b0);
        chkb("abort_busy", oBusy, 1'b0);
        chkb("abort_done", oDone, 1'b0);
        chk("abort_count", oCount, '0);
        step();
        step();
        iRstN = 1'b1;
        iC    = '0;
        repeat (12) begin
            step();
            chkb("abort_idle_busy", oBusy, 1'b0);
        end

        run_window(8, '{3, 8, 0, 5});
        run_window(8, '{7, 1, 6, 2});
        run_window(0, '{1, 1, 1, 1});

        iStart = 1'b1;
        iLen   = 8'd4;
        iC     = '1;
        repeat (3) sb.push_back(exp_vec('{4, 4, 4, 4}, 4));
        for (int t = 1; t <= 21; t++) begin
            step();
            chkb("b2b_done", oDone, t % 7 == 0);
            chkb("b2b_stream", oStreamEn, (t % 7 >= 2) && (t % 7 <= 5));
            if (t == 3) iLen = 8'd9;
            if (t == 5) iLen = 8'd4;
        end
        iStart = 1'b0;
        iC     = '0;
        step();
        chkb("b2b_idle", oBusy, 1'b0);

        run_window(16, '{4, 16, 0, 10});
        run_window(1, '{1, 0, 1, 0});

        repeat (3) step();
        chk("sb_empty", LANES*OW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usadd_window_ctrl.md
Name: usadd_window_ctrl

Overview:
Sequences a bank of LANES unary scaled adders (uSADD) over one fixed-length bitstream window. It clears the adders, opens the stream-enable window for iLen cycles and counts the 1s on each adder output. It then publishes per-lane counts with a start/done handshake. It sits between the SFFT stage sequencer and the per-butterfly uSADD bank.

Parameters:
LANES, 4, number of uSADD lanes controlled
LENW, 8, width of window length; max window 2^LENW-1 cycles
CW, LENW, per-lane count width (count never exceeds iLen)

Ports:
iClk  input  1  clock
iRstN  input  1  asynchronous active-low reset
iStart  input  1  start-window request, sampled in IDLE/DONE only
iLen  input  LENW  window length, latched on accepted iStart
iC  input  LANES  oC outputs of the uSADD lanes, bit i = lane i
oLaneRstN  output  1  registered active-low clear to the uSADD iRstN pins
oStreamEn  output  1  high while input bitstreams are to be driven into the lanes
oBusy  output  1  high from accepted start until DONE
oDone  output  1  one-cycle pulse when results are valid
oCount  output  LANES*CW  per-lane 1s count, lane i at [i*CW +: CW]

Behaviour:
- Reset (async, iRstN low): state=IDLE; oLaneRstN=1; oStreamEn=0; oBusy=0; oDone=0; oCount=0; internal counters=0. Reset mid-window aborts the window with no done pulse.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: when iStart=1, latch iLen into len_q and go to CLEAR. oBusy rises the next cycle.
- Zero length: if latched iLen=0, go CLEAR->DONE. oCount is all zero and oDone pulses.
- CLEAR: exactly 1 cycle. oLaneRstN=0, driven from a flop so it is glitch-free. Per-lane count registers are zeroed.
- RUN: oStreamEn=1 for exactly len_q cycles, tracked by a down-counter that wraps nowhere. Leave to DRAIN after the cycle in which the counter reaches 1.
- Latency: uSADD output lags its input by one register. Lane i count increments when en_d1=1 and iC[i]=1, where en_d1 is oStreamEn delayed one cycle.
- DRAIN: 1 cycle, so the final en_d1 sample is counted.
- DONE: oDone=1 for this single cycle. oBusy=0 in the cycle after DONE. oCount holds until the next CLEAR.
- Back-to-back: iStart=1 while in DONE is accepted and goes directly to CLEAR.
- iStart while busy (CLEAR/RUN/DRAIN) is ignored. iLen changes after acceptance have no effect.
- Counts are unsigned and saturate at 2^CW-1. Saturation is unreachable when CW>=LENW but is kept as a guard.
- Expected value: count ≈ len*(pA+pB)/2 per lane; the controller does not check this.

Optional Feature:
USADD_CTRL_BIPOLAR_EN
- Defined: oCount lanes are signed two's-complement, width CW+1, with value 2*count - len_q. This is computed in the DRAIN->DONE transition, so it is valid when oDone=1. The oCount port width becomes LANES*(CW+1).
- Undefined: unsigned raw counts as above.

Decomposition:
- Shared package usadd_ctrl_pkg:
  - FSM state encoding (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4; 3 bits).
  - Default LANES/LENW constants.
  - Lane-slice width helper.
- One natural sub-module, usadd_lane_cnt: a per-lane saturating counter with sync clear, enable and optional bipolar conversion, generated LANES times.

Test Plan:
- Reset mid-RUN: iStart, iLen=10; assert iRstN low at RUN cycle 4. Expect all outputs at reset values, no oDone, and a clean restart on the next iStart.
- Basic window: LANES=4, iLen=8; lane streams make iC=1 in 3/8/0/5 of the en_d1 cycles. Expect oCount={5,0,8,3} (lane3..lane0), oDone one pulse 1+8+1 cycles after the CLEAR cycle, and oStreamEn high exactly 8 cycles.
- Clear check: pre-load counts with a previous window, then start a new window. Expect oLaneRstN low exactly 1 cycle, and counts exclude any iC activity during CLEAR.
- Zero length: iLen=0. Expect oStreamEn never high, oCount=0, and oDone pulse 2 cycles after iStart.
- Back-to-back and ignored start: iStart held high continuously with iLen=4. Expect windows every 7 cycles (CLEAR+4 RUN+DRAIN+DONE) and mid-window iStart pulses ignored.
- Bipolar (USADD_CTRL_BIPOLAR_EN): iLen=16, lane count 4. Expect oCount lane = -8; count 16 gives +16.
